// File: rtl/smart_car_pkg.sv
// Shared constants, FSM encoding and byte-class helpers for the UART joystick command decoder.
package smart_car_pkg;

  localparam int unsigned CNT_W = 20;

  localparam logic [7:0] AsciiC     = 8'h43;
  localparam logic [7:0] AsciiW     = 8'h57;
  localparam logic [7:0] AsciiS     = 8'h53;
  localparam logic [7:0] AsciiPlus  = 8'h2B;
  localparam logic [7:0] AsciiMinus = 8'h2D;
  localparam logic [7:0] AsciiSemi  = 8'h3B;
  localparam logic [7:0] Ascii0     = 8'h30;
  localparam logic [7:0] Ascii9     = 8'h39;

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StField,
    StTerm,
    StDiscard
  } dec_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= Ascii0) && (b <= Ascii9);
  endfunction

  function automatic logic is_sign(input logic [7:0] b);
    return (b == AsciiPlus) || (b == AsciiMinus);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-strobe input and wheel-command outputs of the command decoder.
// master = UART/divider side, slave = decoder side.
interface uart_cmd_decoder_if;
  import smart_car_pkg::*;

  logic             rxdone;
  logic [7:0]       rxdata;
  logic [CNT_W-1:0] lsd;
  logic [CNT_W-1:0] rsd;
  logic             ldir;
  logic             rdir;
  logic             cmd_valid;
  logic             cmd_err;

  modport master (
    output rxdone, rxdata,
    input  lsd, rsd, ldir, rdir, cmd_valid, cmd_err
  );

  modport slave (
    input  rxdone, rxdata,
    output lsd, rsd, ldir, rdir, cmd_valid, cmd_err
  );

endinterface

// File: rtl/dec2_to_bin.sv
// Two ASCII decimal digits to a 7-bit binary magnitude (0..99), purely combinational.
module dec2_to_bin
  import smart_car_pkg::*;
(
  input  logic [7:0] tens_i,
  input  logic [7:0] units_i,
  output logic [6:0] bin_o
);

  logic [6:0] tens;
  logic [6:0] units;

  assign tens  = 7'(tens_i - Ascii0);
  assign units = 7'(units_i - Ascii0);

  // 10*t as shift-add keeps this multiplier-free.
  assign bin_o = (tens << 3) + (tens << 1) + units;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles ASCII joystick frames ("CW+dd-dd;" / "CS;") into wheel half-period counts.
// Optional watchdog zeroing the speeds after TIMEOUT idle cycles: define UART_CMD_WDOG_EN.
module uart_cmd_decoder
  import smart_car_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_CNT  = 20'd50000,
  parameter logic [CNT_W-1:0] STEP_CNT = 20'd450,
  parameter logic [31:0]      TIMEOUT  = 32'd25000000
) (
  input  logic                clk0,
  input  logic                rst,
  uart_cmd_decoder_if.slave   cmd_io
);

  dec_state_e state_q, state_d;
  logic [2:0] slot_q, slot_d;

  logic       rx_semi;
  logic       field_ok;
  logic       commit;
  logic       err;

  logic       stop_q;
  logic       sign_l_q, sign_r_q;
  logic [7:0] dl1_q, dl0_q, dr1_q, dr0_q;

  logic [6:0]       mag_l, mag_r;
  logic [CNT_W-1:0] lsd_q, rsd_q;
  logic             ldir_q, rdir_q;
  logic             cmd_valid_q, cmd_err_q;
  logic             expire;

  assign rx_semi  = (cmd_io.rxdata == AsciiSemi);
  assign field_ok = ((slot_q == 3'd0) || (slot_q == 3'd3)) ? is_sign(cmd_io.rxdata)
                                                           : is_digit(cmd_io.rxdata);

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (cmd_io.rxdone) begin
      case (state_q)
        StIdle: begin
          if (cmd_io.rxdata == AsciiC) state_d = StType;
        end
        StType: begin
          if (cmd_io.rxdata == AsciiW) begin
            state_d = StField;
            slot_d  = 3'd0;
          end else if (cmd_io.rxdata == AsciiS) begin
            state_d = StTerm;
          end else begin
            state_d = StDiscard;
          end
        end
        StField: begin
          if (!field_ok) begin
            state_d = StDiscard;
          end else if (slot_q == 3'd5) begin
            state_d = StTerm;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
        StTerm:    state_d = rx_semi ? StIdle : StDiscard;
        StDiscard: if (rx_semi) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    commit = 1'b0;
    err    = 1'b0;
    if (cmd_io.rxdone) begin
      case (state_q)
        StType:  err = (cmd_io.rxdata != AsciiW) && (cmd_io.rxdata != AsciiS);
        StField: err = !field_ok;
        StTerm: begin
          commit = rx_semi;
          err    = !rx_semi;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      stop_q   <= 1'b0;
      sign_l_q <= 1'b0;
      sign_r_q <= 1'b0;
      dl1_q    <= Ascii0;
      dl0_q    <= Ascii0;
      dr1_q    <= Ascii0;
      dr0_q    <= Ascii0;
    end else if (cmd_io.rxdone) begin
      if (state_q == StType) stop_q <= (cmd_io.rxdata == AsciiS);
      if (state_q == StField) begin
        case (slot_q)
          3'd0:    sign_l_q <= (cmd_io.rxdata == AsciiPlus);
          3'd1:    dl1_q    <= cmd_io.rxdata;
          3'd2:    dl0_q    <= cmd_io.rxdata;
          3'd3:    sign_r_q <= (cmd_io.rxdata == AsciiPlus);
          3'd4:    dr1_q    <= cmd_io.rxdata;
          3'd5:    dr0_q    <= cmd_io.rxdata;
          default: ;
        endcase
      end
    end
  end

  dec2_to_bin u_dec_l (
    .tens_i  (dl1_q),
    .units_i (dl0_q),
    .bin_o   (mag_l)
  );

  dec2_to_bin u_dec_r (
    .tens_i  (dr1_q),
    .units_i (dr0_q),
    .bin_o   (mag_r)
  );

  // Full 27-bit product, result truncated back to the counter width.
  function automatic logic [CNT_W-1:0] mag_to_cnt(input logic [6:0] mag);
    logic [26:0] prod;
    prod = 27'(mag) * 27'(STEP_CNT);
    return (mag == 7'd0) ? '0 : CNT_W'(27'(MAX_CNT) - prod);
  endfunction

`ifdef UART_CMD_WDOG_EN
  logic [31:0] wdog_q, wdog_d;

  always_comb begin
    if (commit) begin
      wdog_d = '0;
    end else if (wdog_q == TIMEOUT) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + 32'd1;
    end
    expire = !commit && (wdog_q != TIMEOUT) && (wdog_d == TIMEOUT);
  end

  always_ff @(posedge clk0) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk0) begin
    if (rst) begin
      lsd_q       <= '0;
      rsd_q       <= '0;
      ldir_q      <= 1'b0;
      rdir_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_valid_q <= commit;
      cmd_err_q   <= err;
      if (commit) begin
        if (stop_q) begin
          lsd_q <= '0;
          rsd_q <= '0;
        end else begin
          lsd_q  <= mag_to_cnt(mag_l);
          rsd_q  <= mag_to_cnt(mag_r);
          ldir_q <= sign_l_q;
          rdir_q <= sign_r_q;
        end
      end else if (expire) begin
        lsd_q <= '0;
        rsd_q <= '0;
      end
    end
  end

  assign cmd_io.lsd       = lsd_q;
  assign cmd_io.rsd       = rsd_q;
  assign cmd_io.ldir      = ldir_q;
  assign cmd_io.rdir      = rdir_q;
  assign cmd_io.cmd_valid = cmd_valid_q;
  assign cmd_io.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame-template reference model checked every cycle,
// plus literal expectations for the directed frames.
module tb_uart_cmd_decoder;

  localparam int MaxCnt  = 50000;
  localparam int StepCnt = 450;
  localparam int Tmo     = 1000;

  logic clk0;
  logic rst;
  uart_cmd_decoder_if cmd_if ();

  uart_cmd_decoder #(
    .TIMEOUT (32'(Tmo))
  ) dut (
    .clk0   (clk0),
    .rst    (rst),
    .cmd_io (cmd_if)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the current frame are matched against templates.
  bit              armed = 0;
  bit              in_frame, dead;
  byte unsigned    fbuf[$];
  int              m_lsd, m_rsd, m_ldir, m_rdir, m_valid, m_err;
`ifdef UART_CMD_WDOG_EN
  int              m_idle;
`endif

  function automatic bit fits(input string t);
    byte unsigned tc, c;
    if (fbuf.size() > t.len()) return 0;
    for (int i = 0; i < fbuf.size(); i++) begin
      tc = t[i];
      c  = fbuf[i];
      if (tc == "s") begin
        if (c != "+" && c != "-") return 0;
      end else if (tc == "d") begin
        if (c < "0" || c > "9") return 0;
      end else if (c != tc) begin
        return 0;
      end
    end
    return 1;
  endfunction

  function automatic int cnt_of(input byte unsigned t, input byte unsigned u);
    int m;
    m = (int'(t) - 48) * 10 + (int'(u) - 48);
    return (m == 0) ? 0 : MaxCnt - m * StepCnt;
  endfunction

  task automatic model_byte(input byte unsigned b, output bit committed);
    bit ok_w, ok_s;
    committed = 0;
    if (dead) begin
      if (b == ";") dead = 0;
    end else if (!in_frame) begin
      if (b == "C") begin
        in_frame = 1;
        fbuf.delete();
        fbuf.push_back(b);
      end
    end else begin
      fbuf.push_back(b);
      ok_w = fits("CWsddsdd;");
      ok_s = fits("CS;");
      if (!ok_w && !ok_s) begin
        m_err    = 1;
        dead     = 1;
        in_frame = 0;
      end else if (ok_s && fbuf.size() == 3) begin
        m_lsd = 0;
        m_rsd = 0;
        m_valid = 1;
        committed = 1;
        in_frame = 0;
      end else if (ok_w && fbuf.size() == 9) begin
        m_lsd  = cnt_of(fbuf[3], fbuf[4]);
        m_rsd  = cnt_of(fbuf[6], fbuf[7]);
        m_ldir = (fbuf[2] == "+");
        m_rdir = (fbuf[5] == "+");
        m_valid = 1;
        committed = 1;
        in_frame = 0;
      end
    end
  endtask

  always @(posedge clk0) begin
    bit committed;
    committed = 0;
    if (rst) begin
      m_lsd = 0; m_rsd = 0; m_ldir = 0; m_rdir = 0; m_valid = 0; m_err = 0;
      in_frame = 0;
      dead = 0;
      fbuf.delete();
`ifdef UART_CMD_WDOG_EN
      m_idle = 0;
`endif
      armed = 1;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (cmd_if.rxdone) model_byte(cmd_if.rxdata, committed);
`ifdef UART_CMD_WDOG_EN
      if (committed) begin
        m_idle = 0;
      end else if (m_idle < Tmo) begin
        m_idle++;
        if (m_idle == Tmo) begin
          m_lsd = 0;
          m_rsd = 0;
        end
      end
`endif
    end
  end

  always @(negedge clk0) begin
    if (armed) begin
      check("cmp_lsd", 32'(cmd_if.lsd), m_lsd);
      check("cmp_rsd", 32'(cmd_if.rsd), m_rsd);
      check("cmp_ldir", 32'(cmd_if.ldir), m_ldir);
      check("cmp_rdir", 32'(cmd_if.rdir), m_rdir);
      check("cmp_valid", 32'(cmd_if.cmd_valid), m_valid);
      check("cmp_err", 32'(cmd_if.cmd_err), m_err);
    end
  end

  // Called at a negedge; returns at the negedge after the byte's sampling posedge.
  task automatic send_byte(input byte unsigned b);
    cmd_if.rxdone = 1'b1;
    cmd_if.rxdata = b;
    @(negedge clk0);
    cmd_if.rxdone = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk0);
  endtask

  task automatic expect_out(input string tag, input int lsd, input int rsd,
                            input int ldir, input int rdir);
    check({tag, "_lsd"}, 32'(cmd_if.lsd), lsd);
    check({tag, "_rsd"}, 32'(cmd_if.rsd), rsd);
    check({tag, "_ldir"}, 32'(cmd_if.ldir), ldir);
    check({tag, "_rdir"}, 32'(cmd_if.rdir), rdir);
    check({tag, "_model_lsd"}, m_lsd, lsd);
    check({tag, "_model_rsd"}, m_rsd, rsd);
  endtask

  initial begin
    rst = 1'b1;
    cmd_if.rxdone = 1'b0;
    cmd_if.rxdata = 8'h00;
    idle(3);
    rst = 1'b0;
    expect_out("reset", 0, 0, 0, 0);
    check("reset_valid", 32'(cmd_if.cmd_valid), 0);
    check("reset_err", 32'(cmd_if.cmd_err), 0);

    send_str("CW+50-99;");
    check("t1_valid", 32'(cmd_if.cmd_valid), 1);
    expect_out("t1", 27500, 5450, 1, 0);
    idle(1);
    check("t1_valid_drop", 32'(cmd_if.cmd_valid), 0);

    send_str("CW+00+01;");
    expect_out("t2", 0, 49550, 1, 1);
    idle(2);
    send_str("CS;");
    check("t2_stop_valid", 32'(cmd_if.cmd_valid), 1);
    expect_out("t2_stop", 0, 0, 1, 1);

    send_str("CW+5A");
    check("t3_err", 32'(cmd_if.cmd_err), 1);
    send_str("-99;");
    idle(1);
    expect_out("t3_hold", 0, 0, 1, 1);
    send_str("CW-10+10;");
    expect_out("t3_next", 45500, 45500, 0, 1);

    // ';' inside the fields errs; the following "CS" is swallowed by the discard.
    send_str("CW+5;");
    check("semi_err", 32'(cmd_if.cmd_err), 1);
    send_str("CS;");
    idle(1);
    expect_out("semi_hold", 45500, 45500, 0, 1);

    send_byte(8'h0D);
    send_byte(8'h0A);
    send_str("CX");
    check("t4_err", 32'(cmd_if.cmd_err), 1);
    send_str(";");
    send_str("CW+10+10;");
    expect_out("t4_next", 45500, 45500, 1, 1);

    send_str("CW+1");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    expect_out("t5_reset", 0, 0, 0, 0);
    send_str("0+10;");
    idle(2);
    expect_out("t5_orphan", 0, 0, 0, 0);

    send_str("CW+99+99;");
    expect_out("t6_set", 5450, 5450, 1, 1);
    idle(Tmo + 100);
`ifdef UART_CMD_WDOG_EN
    expect_out("t6_wdog", 0, 0, 1, 1);
`else
    expect_out("t6_hold", 5450, 5450, 1, 1);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
